// File: rtl/button_conditioner.sv
// Input conditioning for the bitwise calculator: two-flop synchronisers on all
// raw inputs, plus a per-button debounce FSM that emits one strobe per press.
module button_conditioner #(
  parameter int N_BTN     = 3,
  parameter int SW_W      = 13,
  parameter int DB_CYCLES = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [SW_W-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [SW_W-1:0]  sw_sync
);

  localparam int CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    RISE_WAIT,
    HIGH,
    FALL_WAIT
  } db_state_e;

  logic [N_BTN-1:0] btn_s1;
  logic [N_BTN-1:0] btn_s2;
  logic [SW_W-1:0]  sw_s1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse s1/s2.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      sw_s1   <= '0;
      sw_sync <= '0;
    end else begin
      btn_s1  <= btn_raw;
      btn_s2  <= btn_s1;
      sw_s1   <= sw_raw;
      sw_sync <= sw_s1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    db_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             pulse;

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        state <= LOW;
        cnt   <= '0;
        level <= 1'b0;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        case (state)
          LOW: begin
            if (btn_s2[i]) begin
              state <= RISE_WAIT;
              cnt   <= CNT_W'(1);
            end
          end
          RISE_WAIT: begin
            if (!btn_s2[i]) begin
              state <= LOW;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              state <= HIGH;
              cnt   <= '0;
              level <= 1'b1;
              pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HIGH: begin
            if (!btn_s2[i]) begin
              state <= FALL_WAIT;
              cnt   <= CNT_W'(1);
            end
          end
          FALL_WAIT: begin
            // A short low excursion is a release bounce: stay pressed, no new pulse.
            if (btn_s2[i]) begin
              state <= HIGH;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              state <= LOW;
              cnt   <= '0;
              level <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= LOW;
            cnt   <= '0;
            level <= 1'b0;
          end
        endcase
      end
    end

    assign btn_level[i] = level;
    assign btn_pulse[i] = pulse;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with DB_CYCLES=4:
// press latency, bounce rejection, release bounce, switches, reset, simultaneity.
module tb_button_conditioner;

  logic        clk;
  logic        rst;
  logic [2:0]  btn_raw;
  logic [12:0] sw_raw;
  logic [2:0]  btn_level;
  logic [2:0]  btn_pulse;
  logic [12:0] sw_sync;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .N_BTN    (3),
    .SW_W     (13),
    .DB_CYCLES(4)
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .sw_sync  (sw_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step n cycles, checking pulse and level after each rising edge.
  task automatic step_check(input string tag, input int n,
                            input logic [2:0] pulse_exp, input logic [2:0] level_exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_pulse"}, 32'(btn_pulse), 32'(pulse_exp));
      check({tag, "_level"}, 32'(btn_level), 32'(level_exp));
    end
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = '0;
    sw_raw  = '0;
    repeat (2) @(negedge clk);
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_pulse", 32'(btn_pulse), 32'h0);
    check("rst_sw",    32'(sw_sync),   32'h0);
    rst = 1'b0;

    // Clean press of LoadA: pulse after the 6th edge counting the first sample.
    btn_raw = 3'b001;
    step_check("t1_wait", 5, 3'b000, 3'b000);
    step_check("t1_hit",  1, 3'b001, 3'b001);
    step_check("t1_hold", 14, 3'b000, 3'b001);
    btn_raw = 3'b000;
    step_check("t1_rel",  5, 3'b000, 3'b001);
    step_check("t1_low",  1, 3'b000, 3'b000);

    // Press bounce on LoadB, then steady.
    btn_raw = 3'b010; step_check("t2_b1", 1, 3'b000, 3'b000);
    btn_raw = 3'b000; step_check("t2_b0", 1, 3'b000, 3'b000);
    btn_raw = 3'b010; step_check("t2_b1", 1, 3'b000, 3'b000);
    btn_raw = 3'b000; step_check("t2_b0", 1, 3'b000, 3'b000);
    btn_raw = 3'b010;
    step_check("t2_wait", 5, 3'b000, 3'b000);
    step_check("t2_hit",  1, 3'b010, 3'b010);
    step_check("t2_hold", 2, 3'b000, 3'b010);
    btn_raw = 3'b000;
    step_check("t2_rel",  5, 3'b000, 3'b010);
    step_check("t2_low",  1, 3'b000, 3'b000);

    // Release bounce on Execute: level stays high, no second pulse.
    btn_raw = 3'b100;
    step_check("t3_wait", 5, 3'b000, 3'b000);
    step_check("t3_hit",  1, 3'b100, 3'b100);
    step_check("t3_hold", 3, 3'b000, 3'b100);
    btn_raw = 3'b000;
    step_check("t3_gap",  2, 3'b000, 3'b100);
    btn_raw = 3'b100;
    step_check("t3_back", 8, 3'b000, 3'b100);
    btn_raw = 3'b000;
    step_check("t3_rel",  5, 3'b000, 3'b100);
    step_check("t3_low",  1, 3'b000, 3'b000);

    // Switches: two-edge synchroniser, no debounce.
    sw_raw = 13'h0D6A;
    @(negedge clk);
    check("t4_sw_e1", 32'(sw_sync), 32'h0);
    @(negedge clk);
    check("t4_sw_e2", 32'(sw_sync), 32'h0D6A);

    // Reset mid-debounce: clears everything immediately and cancels the press.
    btn_raw = 3'b001;
    step_check("t5_pre", 3, 3'b000, 3'b000);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_level", 32'(btn_level), 32'h0);
    check("t5_rst_pulse", 32'(btn_pulse), 32'h0);
    check("t5_rst_sw",    32'(sw_sync),   32'h0);
    #1 rst = 1'b0;
    step_check("t5_wait", 5, 3'b000, 3'b000);
    step_check("t5_hit",  1, 3'b001, 3'b001);
    step_check("t5_hold", 4, 3'b000, 3'b001);
    btn_raw = 3'b000;
    step_check("t5_rel",  5, 3'b000, 3'b001);
    step_check("t5_low",  1, 3'b000, 3'b000);

    // Simultaneous presses: all pulses in one cycle.
    btn_raw = 3'b111;
    step_check("t6_wait", 5, 3'b000, 3'b000);
    step_check("t6_hit",  1, 3'b111, 3'b111);
    step_check("t6_hold", 1, 3'b000, 3'b111);
    btn_raw = 3'b000;
    step_check("t6_rel",  5, 3'b000, 3'b111);
    step_check("t6_low",  1, 3'b000, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input conditioning stage directly upstream of the bitwise calculator Processor core.
- Takes raw board push-buttons (LoadA, LoadB, Execute) and slide switches (Din, F, R).
- Synchronises every input to Clk; debounces each button.
- Emits one single-cycle strobe per physical press plus synchronised switch values, so the Processor sees clean, glitch-free control.

Parameters:
N_BTN, 3, number of push-buttons conditioned (bit 0 LoadA, bit 1 LoadB, bit 2 Execute)
SW_W, 13, switch bus width (bits 7:0 Din, 10:8 F, 12:11 R)
DB_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (min 2; board builds override, sims use 4)

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous active-high reset
btn_raw  input  N_BTN  raw button levels, active-high, asynchronous to Clk
sw_raw  input  SW_W  raw switch levels, asynchronous to Clk
btn_level  output  N_BTN  debounced button level
btn_pulse  output  N_BTN  one-cycle strobe on debounced rising edge
sw_sync  output  SW_W  two-flop synchronised switch values

Behaviour:
- Reset (async assert, any time, including mid-count):
  - All sync flops, counters, btn_level, btn_pulse and sw_sync clear to 0.
  - Every button FSM returns to LOW.
- Synchroniser:
  - Each bit of btn_raw and sw_raw passes through two flops (s1, s2). Only s2 is used downstream.
  - sw_sync = s2 of sw_raw. Latency 2 edges; no debounce on switches.
- Per-button FSM, fully independent across buttons:
  - States: LOW, RISE_WAIT, HIGH, FALL_WAIT. Each button has its own counter, width clog2(DB_CYCLES)+1.
  - LOW: s2=1 -> RISE_WAIT, cnt=1.
  - RISE_WAIT:
    - s2=0 -> LOW, cnt=0.
    - s2=1 and cnt==DB_CYCLES-1 -> HIGH, btn_level<=1, btn_pulse<=1.
    - Otherwise cnt++.
  - HIGH: s2=0 -> FALL_WAIT, cnt=1.
  - FALL_WAIT:
    - s2=1 -> HIGH, cnt=0.
    - s2=0 and cnt==DB_CYCLES-1 -> LOW, btn_level<=0.
    - Otherwise cnt++.
- Outputs:
  - btn_level is asserted only in HIGH and FALL_WAIT.
  - btn_pulse is registered and high for exactly one cycle per LOW->HIGH acceptance, regardless of hold length. No pulse on release.
- Latency: btn_raw rising before edge k with no bounce -> btn_level and btn_pulse high after edge k+1+DB_CYCLES. That is 2 sync edges plus DB_CYCLES stable samples, with the first stable sample at edge k+1.
- Glitch rejection:
  - Any bounce shorter than DB_CYCLES samples returns the FSM to its prior stable state with no output change.
  - A bounce during RISE_WAIT restarts the count from zero on the next 1.
- Simultaneous presses on several buttons produce pulses in the same cycle if the timing is identical. No priority or arbitration; the Processor handles overlap.
- Counter never exceeds DB_CYCLES-1; no wrap-around.
- Button held across Reset deassertion is treated as a new press: one pulse 2+DB_CYCLES edges after the first post-reset edge.
- Reset asserted during RISE_WAIT cancels the pending press; no pulse.

Test Plan:
- DB_CYCLES=4. Reset 2 cycles, then btn_raw=3'b001 held 20 cycles -> btn_pulse[0] high exactly 1 cycle, 6 edges after first sample; btn_level[0] high until release+6 edges; btn_pulse[2:1]=0 throughout.
- Bounce: btn_raw[1] toggles 1,0,1,0 one cycle each, then steady 1 -> no pulse during bounce; single pulse 6 edges after steady 1 begins.
- Release bounce: hold btn_raw[2] until level=1, then 0 for 2 cycles, back to 1 -> btn_level[2] stays 1 with no second pulse; final release -> level 0 after 6 edges with no pulse.
- sw_raw=13'h0D6A (Din=8'h6A, F=3'b101, R=2'b01) -> sw_sync equals 13'h0D6A after 2 edges; 0 before.
- Reset mid-operation: btn_raw[0]=1 for 3 cycles, then Reset pulse (async, between edges) -> all outputs 0 immediately. btn_raw[0] held -> exactly one pulse 6 edges after first post-reset edge.
- Simultaneous: btn_raw=3'b111 at one edge -> btn_pulse=3'b111 in the same single cycle, then 3'b000.
